dalu_sched: RTL and testbench



---
 rtl/dalu_sched_if.sv | 25 ++
 rtl/dalu_sched.sv | 170 +++++++++++++++++
 tb/tb_dalu_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dalu_sched_if.sv
// Request/response bundle for dalu_sched: two packed requester lanes and one
// tagged response channel. master = requesters + consumer, slave = scheduler.
interface dalu_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [5:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_id;
   logic        rsp_zero;
   logic        rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err
   );
endinterface

// File: rtl/dalu_sched.sv
// Round-robin scheduler/sequencer sharing one 8-bit dALU between two requesters.
// Define DALU_SCHED_MUL_EN to build the 8-cycle shift-add multiply (op 4).
module dalu_sched #(
   parameter int RR_INIT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   dalu_sched_if.slave  bus
);
   localparam int   DATA_W    = 8;
   localparam logic RR_INIT_B = (RR_INIT != 0);

   typedef logic [DATA_W-1:0] data_t;

`ifdef DALU_SCHED_MUL_EN
   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

   function automatic data_t dalu(input data_t a, input data_t b, input logic [1:0] op);
      case (op)
         2'd1:    return a | b;
         2'd2:    return a & b;
         2'd3:    return a + b;
         default: return '0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        rr_q;
   logic        gnt_id;
   logic        accept;
   data_t       sel_a, sel_b;
   logic [2:0]  sel_op;
   data_t       a_q, b_q;
   logic [1:0]  op_q;
   logic        id_q;
   data_t       alu_a, alu_b, alu_y;
   logic [1:0]  alu_op;
   data_t       rsp_data_q;
   logic        rsp_id_q, rsp_err_q;
`ifdef DALU_SCHED_MUL_EN
   data_t       acc_q;
   logic [2:0]  cnt_q;
`endif

   // A lone requester always wins; on contention the pointer decides.
   always_comb begin
      gnt_id = rr_q;
      if (bus.req_valid == 2'b01)      gnt_id = 1'b0;
      else if (bus.req_valid == 2'b10) gnt_id = 1'b1;
   end

   assign accept        = (state_q == IDLE) && (bus.req_valid != 2'b00);
   assign bus.req_ready = accept ? (2'b01 << gnt_id) : 2'b00;
   assign sel_a         = gnt_id ? bus.req_a[15:8] : bus.req_a[7:0];
   assign sel_b         = gnt_id ? bus.req_b[15:8] : bus.req_b[7:0];
   assign sel_op        = gnt_id ? bus.req_op[5:3] : bus.req_op[2:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sel_op <= 3'd3)       state_d = EXEC;
`ifdef DALU_SCHED_MUL_EN
               else if (sel_op == 3'd4)  state_d = MUL;
`endif
               else                      state_d = RESP;
            end
         end
         EXEC: state_d = RESP;
`ifdef DALU_SCHED_MUL_EN
         MUL:  if (cnt_q == 3'd7) state_d = RESP;
`endif
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
`ifdef DALU_SCHED_MUL_EN
      if (state_q == MUL) begin
         alu_a  = acc_q;
         alu_b  = b_q[cnt_q] ? data_t'(a_q << cnt_q) : '0;
         alu_op = 2'd3;
      end
`endif
   end

   assign alu_y = dalu(alu_a, alu_b, alu_op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= RR_INIT_B;
      end else begin
         state_q <= state_d;
         if (accept) rr_q <= ~gnt_id;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= sel_a;
         b_q  <= sel_b;
         op_q <= sel_op[1:0];
         id_q <= gnt_id;
      end
   end

`ifdef DALU_SCHED_MUL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (state_q == MUL) begin
         acc_q <= alu_y;
         cnt_q <= cnt_q + 3'd1;
      end
   end
`endif

   // Response register: illegal ops skip the dALU and respond straight from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && (state_d == RESP)) begin
                  rsp_data_q <= '0;
                  rsp_id_q   <= gnt_id;
                  rsp_err_q  <= 1'b1;
               end
            end
            EXEC: begin
               rsp_data_q <= alu_y;
               rsp_id_q   <= id_q;
               rsp_err_q  <= 1'b0;
            end
`ifdef DALU_SCHED_MUL_EN
            MUL: begin
               if (cnt_q == 3'd7) begin
                  rsp_data_q <= alu_y;
                  rsp_id_q   <= id_q;
                  rsp_err_q  <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_zero  = (rsp_data_q == '0);
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dalu_sched.sv
// Self-checking bench for dalu_sched: directed scenarios with literal results
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_dalu_sched;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dalu_sched_if bus();

   dalu_sched #(.RR_INIT(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result, error flag and issue-to-valid latency of one request.
   function automatic void model_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                    output logic [7:0] d, output logic e, output int lat);
      d = 8'h00; e = 1'b0; lat = 1;
      case (op)
         3'd0: d = 8'h00;
         3'd1: d = a | b;
         3'd2: d = a & b;
         3'd3: d = 8'((int'(a) + int'(b)) % 256);
`ifdef DALU_SCHED_MUL_EN
         3'd4: begin d = 8'((int'(a) * int'(b)) % 256); lat = 8; end
`endif
         default: begin d = 8'h00; e = 1'b1; lat = 0; end
      endcase
   endfunction

   typedef enum {M_IDLE, M_WAIT, M_RESP} mphase_t;
   mphase_t    mph;
   int         mwait;
   logic       mptr;
   logic [7:0] md;
   logic       me, mid;

   // Transaction-level reference: arbitration, busy window and expected response.
   initial begin
      logic [1:0] v, exp_ready;
      logic       w;
      logic [7:0] a, b;
      logic [2:0] op;
      int         lat;
      mph = M_IDLE; mwait = 0; mptr = 1'b0; md = 8'h00; me = 1'b0; mid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mph = M_IDLE; mptr = 1'b0;
            check("rst_rsp_valid", bus.rsp_valid, 0);
            continue;
         end
         v = bus.req_valid;
         w = (v == 2'b11) ? mptr : v[1];
         exp_ready = (mph == M_IDLE && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
         check("req_ready", bus.req_ready, exp_ready);
         check("rsp_valid", bus.rsp_valid, mph == M_RESP);
         if (mph == M_RESP) begin
            check("rsp_data", bus.rsp_data, md);
            check("rsp_id", bus.rsp_id, mid);
            check("rsp_err", bus.rsp_err, me);
            check("rsp_zero", bus.rsp_zero, md == 8'h00);
         end
         case (mph)
            M_IDLE: if (exp_ready != 2'b00) begin
               a  = w ? bus.req_a[15:8] : bus.req_a[7:0];
               b  = w ? bus.req_b[15:8] : bus.req_b[7:0];
               op = w ? bus.req_op[5:3] : bus.req_op[2:0];
               model_op(a, b, op, md, me, lat);
               mid  = w;
               mptr = ~w;
               if (lat == 0) mph = M_RESP;
               else begin mph = M_WAIT; mwait = lat; end
            end
            M_WAIT: begin
               mwait--;
               if (mwait == 0) mph = M_RESP;
            end
            M_RESP: if (bus.rsp_ready) mph = M_IDLE;
            default: mph = M_IDLE;
         endcase
      end
   end

   task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bus.req_a[id*8 +: 8]  = a;
      bus.req_b[id*8 +: 8]  = b;
      bus.req_op[id*3 +: 3] = op;
      bus.req_valid[id]     = 1'b1;
   endtask

   task automatic wait_grant(input int id, input string nm);
      logic got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.req_ready[id]) begin got = 1'b1; break; end
      end
      check({nm, "_accept"}, got, 1);
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
   endtask

   // Single request with rsp_ready high; literal result and latency.
   task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] ed, input logic ee, input int elat, input string nm);
      int lat = -1;
      set_req(id, a, b, op);
      wait_grant(id, nm);
      for (int k = 0; k < 20; k++) begin
         if (k > 0 || 1) @(negedge clk);
         if (bus.rsp_valid) begin lat = k; break; end
      end
      check({nm, "_lat"}, lat, elat);
      check({nm, "_data"}, bus.rsp_data, ed);
      check({nm, "_id"}, bus.rsp_id, id);
      check({nm, "_err"}, bus.rsp_err, ee);
      check({nm, "_zero"}, bus.rsp_zero, ed == 8'h00);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] g, exp_g1;
      int         exp_g, ngr, nrsp;
      logic       rid_q[$];

      rst_n = 1'b0;
      bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_rsp_data", bus.rsp_data, 0);
      check("reset_rsp_id", bus.rsp_id, 0);
      check("reset_rsp_zero", bus.rsp_zero, 1);
      check("reset_rsp_err", bus.rsp_err, 0);
      check("reset_req_ready", bus.req_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;

      issue(0, 8'h02, 8'h03, 3'd1, 8'h03, 1'b0, 1, "r0_or");
      issue(1, 8'hFF, 8'h01, 3'd3, 8'h00, 1'b0, 1, "r1_add_wrap");
      issue(1, 8'hAA, 8'h55, 3'd0, 8'h00, 1'b0, 1, "op0_reserved");
      issue(0, 8'h12, 8'h34, 3'd7, 8'h00, 1'b1, 0, "op7_illegal");
`ifdef DALU_SCHED_MUL_EN
      issue(0, 8'h0D, 8'h0B, 3'd4, 8'h8F, 1'b0, 8, "mul_0d_0b");
      issue(1, 8'h20, 8'h10, 3'd4, 8'h00, 1'b0, 8, "mul_zero");
`else
      issue(0, 8'h0D, 8'h0B, 3'd4, 8'h00, 1'b1, 0, "mul_disabled");
`endif

      // Both requesters continuously valid: grants must alternate from requester 0.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 8'h0F, 8'h3C, 3'd2);
      set_req(1, 8'h0F, 8'h3C, 3'd2);
      exp_g = 0; ngr = 0; nrsp = 0;
      for (int k = 0; k < 60 && (ngr < 4 || nrsp < 4); k++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00 && ngr < 4) begin
            exp_g1 = (exp_g == 0) ? 2'b01 : 2'b10;
            check("rr_grant", bus.req_ready, exp_g1);
            rid_q.push_back(exp_g[0]);
            exp_g ^= 1;
            ngr++;
         end
         if (bus.rsp_valid && nrsp < 4 && rid_q.size() > 0) begin
            check("rr_data", bus.rsp_data, 8'h0C);
            check("rr_id", bus.rsp_id, rid_q.pop_front());
            nrsp++;
         end
      end
      check("rr_count", ngr * 10 + nrsp, 44);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      repeat (12) @(posedge clk); #1;

      // Illegal op under backpressure while the other requester waits.
      bus.rsp_ready = 1'b0;
      set_req(0, 8'h12, 8'h34, 3'd6);
      wait_grant(0, "bp_op6");
      set_req(1, 8'h50, 8'h05, 3'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_rsp_valid", bus.rsp_valid, 1);
         check("bp_rsp_data", bus.rsp_data, 0);
         check("bp_rsp_err", bus.rsp_err, 1);
         check("bp_req_ready", bus.req_ready, 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      wait_grant(1, "bp_follow");
      repeat (4) @(posedge clk); #1;

      // Asynchronous reset during the fourth multiply cycle drops the request.
      set_req(1, 8'h0D, 8'h0B, 3'd4);
      wait_grant(1, "rst_mul");
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rsp_valid", bus.rsp_valid, 0);
      check("arst_rsp_data", bus.rsp_data, 0);
      check("arst_rsp_id", bus.rsp_id, 0);
      check("arst_rsp_zero", bus.rsp_zero, 1);
      check("arst_rsp_err", bus.rsp_err, 0);
      check("arst_req_ready", bus.req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk); #1;
      issue(0, 8'h02, 8'h03, 3'd3, 8'h05, 1'b0, 1, "post_rst_add");

      // Randomized traffic with withdrawals and random backpressure.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         g = bus.req_valid & bus.req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (g[i] || !bus.req_valid[i]) begin
               if ($urandom_range(0, 2) == 0)
                  set_req(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
               else
                  bus.req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
               bus.req_valid[i] = 1'b0;
            end
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
      repeat (20) @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
